sync_data_memory: RTL and testbench
===================================

# sync_data_memory

Parametrised synchronous data memory with a valid/ready request port, fixed configurable read latency, per-byte write enables and a self-clearing initialisation sweep. It serves as the processor's data-memory stage (MEM) and can also be instantiated as instruction memory with writes tied off. Contents are defined by hardware after reset, not by simulation-only preload.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- DEPTH, 32, number of words; need not be a power of two
- ADDR_W, $clog2(DEPTH), word address width
- RD_LAT, 1, read latency in cycles, legal range 1..4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous request to re-run the clear sweep
- req_valid  in  1  request present
- req_ready  out  1  request can be accepted this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables; bit i enables bits [8i+7:8i]
- rsp_valid  out  1  read data valid, one-cycle pulse per read
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  qualifies rsp_valid: address was >= DEPTH
- init_done  out  1  clear sweep complete

## Operation
- One clock, single array port; at most one accepted request per cycle. Accept = req_valid && req_ready.
- States: CLEAR, RUN.
- CLEAR: a counter walks addresses 0..DEPTH-1 and writes 0, one word per cycle. req_ready = 0 and init_done = 0. After the write to DEPTH-1, the next state is RUN.
- RUN: req_ready = 1 and init_done = 1.
- clr sampled high in RUN: go to CLEAR with counter = 0. Reads already in the latency pipe still complete. Their data was captured at accept, so they return pre-clear contents.
- clr high in CLEAR: restart the counter at 0.
- Write: for each set bit of req_be, the corresponding array byte is updated at the accepting edge. req_be = 0 is a legal no-op. Writes produce no response.
- Read: the word is captured at the accepting edge and then delayed RD_LAT-1 further stages.
- Out-of-range address (addr >= DEPTH):
  - write is dropped;
  - read returns rsp_rdata = 0 with rsp_err = 1.
- Read of an address written in an earlier cycle returns the new data. There is no same-cycle read and write.

## Timing
- Reset values:
  - state = CLEAR, counter = 0;
  - req_ready = 0, init_done = 0;
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
  - the latency pipe is flushed.
- After rst_n deasserts, the first cycle with req_ready = 1 is cycle DEPTH, counting the first clock edge as cycle 0.
- Read accepted at edge t: rsp_valid = 1 in the cycle following edge t+RD_LAT-1. Back-to-back reads give back-to-back responses in order.
- The response has no backpressure; the consumer must take the data in that cycle.
- rsp_rdata and rsp_err hold their last value while rsp_valid = 0.
- Reset asserted mid-operation: in-flight responses are discarded immediately, and the partially written array is re-cleared after release.
- Read issued one cycle after a write to the same address returns the written data. No bypass is needed, because the write completes at the accepting edge.

## Structure
- Shared package mem_pkg: state enum (CLEAR, RUN), the RD_LAT legal-range constant, and a be-to-bitmask helper function.
- Sub-module rd_pipe: a valid+data+err shift register of RD_LAT stages with async reset on the valid bits.
- Array, clear FSM and request decode live in the top module.

## Test plan
- Reset, DEPTH = 32: init_done rises after exactly 32 cycles; a read of every address returns 0 with rsp_err = 0.
- Write 0xDEADBEEF to address 5 with req_be = 4'b1111, then write 0x000000AA to address 5 with req_be = 4'b0001; read address 5 → 0xDEADBEAA.
- RD_LAT = 3: reads of addresses 1, 2, 3 on consecutive cycles, after writing 0x11, 0x22, 0x33 → three consecutive rsp_valid pulses starting 3 cycles after the first accept, carrying 0x11, 0x22, 0x33 in order.
- DEPTH = 20, write 0x55 to address 25 then read address 25 → rsp_rdata = 0 with rsp_err = 1; address 19 unchanged.
- Write 0x77 to address 4, issue a read of address 4, assert clr on the next cycle → response 0x77 delivered; req_ready low for DEPTH cycles; a later read of address 4 → 0.
- Assert rst_n low during the clear sweep and during a pending read → rsp_valid never pulses for the pending read; init_done follows the full DEPTH-cycle sweep after release.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for sync_data_memory.
//   state_e      : controller state (clear sweep or normal service)
//   RD_LAT_MIN/MAX: legal range of the read-latency parameter
//   be_to_mask() : expands one byte-enable bit into an 8-bit write mask
package mem_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   // One enable bit covers one byte lane of the word.
   function automatic logic [7:0] be_to_mask(input logic be);
      return {8{be}};
   endfunction

endpackage

// File: rtl/sync_data_memory_rd_pipe.sv
// rd_pipe: read-response delay line of RD_LAT stages.
//   clk, rst_n        : clock, asynchronous active-low reset (flushes the pipe)
//   valid_i/data_i/err_i : response launched at the accepting edge
//   valid_o/data_o/err_o : response after RD_LAT stages; data/err hold
//                          their last value while no response is present
module rd_pipe #(
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              err_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              err_o
);

   logic [RD_LAT-1:0] valid_q;
   logic [RD_LAT-1:0] err_q;
   logic [DATA_W-1:0] data_q [RD_LAT];

   // Shift stages; payload only moves together with a valid bit so the
   // last stage keeps the previous response during bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         err_q   <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= valid_i;
         if (valid_i) begin
            data_q[0] <= data_i;
            err_q[0]  <= err_i;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) begin
               data_q[i] <= data_q[i-1];
               err_q[i]  <= err_q[i-1];
            end
         end
      end
   end

   assign valid_o = valid_q[RD_LAT-1];
   assign data_o  = data_q[RD_LAT-1];
   assign err_o   = err_q[RD_LAT-1];

endmodule

// File: rtl/sync_data_memory.sv
// sync_data_memory: synchronous data memory with valid/ready request port,
// fixed read latency, byte enables and a hardware clear sweep after reset.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr             : re-run the clear sweep
//   req_valid/ready : request handshake (accept = valid && ready)
//   req_we, req_addr, req_wdata, req_be : request fields
//   rsp_valid, rsp_rdata, rsp_err       : read response, RD_LAT cycles later
//   init_done       : array contents are defined (sweep finished)
module sync_data_memory
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                init_done
);

   localparam int                BE_W      = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("sync_data_memory: RD_LAT out of legal range");
   end

   state_e              state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic                req_ready_q;
   logic                init_done_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                accept_s;
   logic                addr_ok_s;
   logic                wr_en_s;
   logic                rd_en_s;
   logic [DATA_W-1:0]   wmask_s;
   logic [DATA_W-1:0]   rd_word_s;

   assign accept_s  = req_valid & req_ready_q;
   // Non-power-of-two DEPTH leaves part of the address space unbacked.
   assign addr_ok_s = ({1'b0, req_addr} < DEPTH_EXT);
   assign wr_en_s   = accept_s & req_we & addr_ok_s;
   assign rd_en_s   = accept_s & ~req_we;

   // Expand byte enables into a per-bit write mask.
   always_comb begin
      wmask_s = '0;
      for (int b = 0; b < BE_W; b++) begin
         wmask_s[8*b +: 8] = be_to_mask(req_be[b]);
      end
   end

   // Read word for the response; out-of-range reads return zero.
   always_comb begin
      if (addr_ok_s) begin
         rd_word_s = mem_q[req_addr];
      end else begin
         rd_word_s = '0;
      end
   end

   // Clear-sweep / run controller with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_CLEAR;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (clr) begin
                  cnt_q <= '0;
               end else if (cnt_q == LAST_ADDR) begin
                  state_q     <= ST_RUN;
                  cnt_q       <= '0;
                  req_ready_q <= 1'b1;
                  init_done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + ADDR_W'(1);
               end
            end
            ST_RUN: begin
               if (clr) begin
                  state_q     <= ST_CLEAR;
                  cnt_q       <= '0;
                  req_ready_q <= 1'b0;
                  init_done_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_CLEAR;
               cnt_q       <= '0;
               req_ready_q <= 1'b0;
               init_done_q <= 1'b0;
            end
         endcase
      end
   end

   // Storage array: zeroed by the sweep, byte-masked writes in RUN.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_en_s) begin
         mem_q[req_addr] <= (mem_q[req_addr] & ~wmask_s) | (req_wdata & wmask_s);
      end
   end

   rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (rd_en_s),
      .data_i  (rd_word_s),
      .err_i   (~addr_ok_s),
      .valid_o (rsp_valid),
      .data_o  (rsp_rdata),
      .err_o   (rsp_err)
   );

   assign req_ready = req_ready_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_sync_data_memory.sv
module tb_sync_data_memory;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 20;
   localparam int ADDR_W = 5;
   localparam int RD_LAT = 3;

   logic              clk;
   logic              rst_n;
   logic              clr;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [3:0]        req_be;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              init_done;

   sync_data_memory #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .init_done (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          at;
   } exp_t;

   exp_t sb_q[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rsp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 data %h expected no response", rsp_rdata);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.data);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            check("rsp_cycle", cyc, e.at);
         end
      end
   end

   task automatic idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = 4'h0;
   endtask

   // Called at a negedge; the request is accepted at the following posedge.
   task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                        input logic [3:0] be, input logic push, input logic [31:0] exp_d,
                        input logic exp_e);
      check("req_ready", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = data;
      req_be    = be;
      if (push) sb_q.push_back('{data: exp_d, err: exp_e, at: cyc + RD_LAT});
      @(negedge clk);
   endtask

   task automatic wr(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic [3:0] be);
      issue(1'b1, addr, data, be, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic rd(input logic [ADDR_W-1:0] addr, input logic [31:0] exp_d, input logic exp_e);
      issue(1'b0, addr, 32'd0, 4'h0, 1'b1, exp_d, exp_e);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
      check("drain_outstanding", sb_q.size(), 32'd0);
   endtask

   // Counts negedges until req_ready rises (bounded).
   task automatic wait_ready(output int n);
      n = 0;
      while (n < 200 && req_ready !== 1'b1) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0;
      clr   = 1'b0;
      idle();
      repeat (3) @(negedge clk);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);

      // Sweep after reset release takes DEPTH cycles.
      rst_n = 1'b1;
      wait_ready(n);
      check("init_cycles", n, DEPTH);
      check("init_done_up", {31'd0, init_done}, 32'd1);

      // Every word reads back zero after the sweep.
      for (int a = 0; a < DEPTH; a++) rd(ADDR_W'(a), 32'd0, 1'b0);
      idle();
      drain();

      // Byte-enable merge.
      wr(5'd5, 32'hDEADBEEF, 4'b1111);
      wr(5'd5, 32'h000000AA, 4'b0001);
      rd(5'd5, 32'hDEADBEAA, 1'b0);
      idle();
      drain();
      repeat (3) @(negedge clk);
      check("hold_rdata", rsp_rdata, 32'hDEADBEAA);
      check("hold_valid_low", {31'd0, rsp_valid}, 32'd0);

      // Back-to-back reads with latency RD_LAT, in order.
      wr(5'd1, 32'h00000011, 4'b1111);
      wr(5'd2, 32'h00000022, 4'b1111);
      wr(5'd3, 32'h00000033, 4'b1111);
      rd(5'd1, 32'h00000011, 1'b0);
      rd(5'd2, 32'h00000022, 1'b0);
      rd(5'd3, 32'h00000033, 1'b0);
      idle();
      drain();

      // be = 0 is a no-op; sparse byte enables.
      wr(5'd2, 32'hFFFFFFFF, 4'b0000);
      wr(5'd3, 32'hAABBCCDD, 4'b1010);
      rd(5'd2, 32'h00000022, 1'b0);
      rd(5'd3, 32'hAA00CC33, 1'b0);
      idle();
      drain();

      // Out-of-range write dropped, read flags error.
      wr(5'd25, 32'h00000055, 4'b1111);
      rd(5'd25, 32'd0, 1'b1);
      rd(5'd19, 32'd0, 1'b0);
      idle();
      drain();

      // clr with a read in flight: old data returned, then array cleared.
      wr(5'd4, 32'h00000077, 4'b1111);
      rd(5'd4, 32'h00000077, 1'b0);
      idle();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_ready_low", {31'd0, req_ready}, 32'd0);
      check("clr_done_low", {31'd0, init_done}, 32'd0);
      wait_ready(n);
      check("clr_sweep_cycles", n, DEPTH);
      drain();
      rd(5'd4, 32'd0, 1'b0);
      rd(5'd5, 32'd0, 1'b0);
      idle();
      drain();

      // Reset with a read pending and again mid-sweep.
      wr(5'd1, 32'h00000011, 4'b1111);
      issue(1'b0, 5'd1, 32'd0, 4'h0, 1'b0, 32'd0, 1'b0);
      idle();
      rst_n = 1'b0;
      #1;
      check("rst_flush_valid", {31'd0, rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("midsweep_done_low", {31'd0, init_done}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_ready(n);
      check("resweep_cycles", n, DEPTH);
      rd(5'd1, 32'd0, 1'b0);
      idle();
      drain();
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
